// File: rtl/change_dispenser.sv
// change_dispenser: inactivity timer plus greedy change return FSM.
// Sits next to the vending machine's combinational next-total stage. When the
// user asks for a return, or the inactivity timer runs out, it hands back one
// coin per cycle, largest denomination first. The next-total stage subtracts
// the returned coin from current_total at the same edge.
//
// Optional build macro: CHANGE_DISPENSE_GAP_EN
//   When defined, RETURN alternates DISPENSE/GAP cycles, and no coin is
//   driven in a GAP cycle. When undefined, a coin is driven every cycle.
module change_dispenser #(
  parameter int kNumCoins  = 3,
  parameter int kNumItems  = 4,
  parameter int kTotalBits = 31,
  parameter int kWaitTime  = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [kNumCoins-1:0]         i_input_coin,
  input  logic [kNumItems-1:0]         i_output_item,
  input  logic                         i_trigger_return,
  input  logic [kNumCoins-1:0][31:0]   coin_value,
  input  logic [kTotalBits-1:0]        current_total,
  output logic [31:0]                  wait_time,
  output logic [kNumCoins-1:0]         o_return_coin,
  output logic                         o_busy
);

  typedef enum logic {S_IDLE = 1'b0, S_RETURN = 1'b1} state_t;

  state_t                state, state_nxt;
  logic                  activity;
  logic                  enter_return;
  logic                  has_total;
  logic                  dispense_phase;
  logic [31:0]           total_ext;
  logic [kNumCoins-1:0]  sel_coin;

  // A coin insert or an item dispense both count as user activity.
  assign activity  = (|i_input_coin) | (|i_output_item);
  assign total_ext = 32'(current_total);
  assign has_total = |current_total;

`ifdef CHANGE_DISPENSE_GAP_EN
  // Phase bit: 0 = DISPENSE, 1 = GAP. Held at DISPENSE while idle so every
  // return starts with a coin.
  logic phase_gap;

  // Toggle the phase on every RETURN cycle; park it at DISPENSE otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 phase_gap <= 1'b0;
    else if (state == S_RETURN) phase_gap <= ~phase_gap;
    else                       phase_gap <= 1'b0;
  end

  assign dispense_phase = ~phase_gap;
`else
  assign dispense_phase = 1'b1;
`endif

  // Greedy pick: the highest-index coin whose value fits in the balance.
  // Scanning upward and overwriting leaves the largest fitting coin, which
  // works because the denominations are strictly ascending.
  always_comb begin
    sel_coin = '0;
    for (int i = 0; i < kNumCoins; i++) begin
      if (coin_value[i] <= total_ext) begin
        sel_coin    = '0;
        sel_coin[i] = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt     = state;
    enter_return  = 1'b0;
    o_return_coin = '0;
    o_busy        = 1'b0;
    case (state)
      S_IDLE: begin
        // A trigger or timeout with an empty balance leaves us idle.
        if (has_total &&
            (i_trigger_return || ((wait_time == 32'd1) && !activity))) begin
          state_nxt    = S_RETURN;
          enter_return = 1'b1;
        end
      end
      S_RETURN: begin
        o_busy = 1'b1;
        if (dispense_phase) o_return_coin = sel_coin;
        // A new coin aborts the return. Otherwise finish once nothing fits,
        // which only counts in a DISPENSE cycle. A coin driven in the abort
        // cycle is still taken by the next-total stage.
        if (activity || (dispense_phase && (sel_coin == '0)))
          state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Inactivity timer. Activity reloads it and wins over entering RETURN.
  // Entering RETURN clears it. Otherwise it counts down and saturates at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   wait_time <= 32'd0;
    else if (activity)           wait_time <= 32'(kWaitTime);
    else if (enter_return)       wait_time <= 32'd0;
    else if (wait_time != 32'd0) wait_time <= wait_time - 32'd1;
  end

`ifndef SYNTHESIS
  // At most one coin is handed out per cycle.
  a_onehot_return: assert property (@(posedge clk) disable iff (reset)
    $onehot0(o_return_coin));
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: table-driven vectors, hand-written corner sequences,
// and randomized traffic checked against a behavioural reference model.
// The bench plays the part of the top-level total register: each edge it adds
// inserted coins to current_total and subtracts the returned coin.
module tb_change_dispenser;
  localparam int NC = 3;
  localparam int NI = 4;
  localparam int TW = 31;
  localparam int WT = 10;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NC-1:0]          i_input_coin;
  logic [NI-1:0]          i_output_item;
  logic                   i_trigger_return;
  logic [NC-1:0][31:0]    coin_value;
  logic [TW-1:0]          current_total;
  logic [31:0]            wait_time;
  logic [NC-1:0]          o_return_coin;
  logic                   o_busy;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  bit          m_busy;
  bit          m_phase;   // 1 = gap cycle
  int unsigned m_wt;

  change_dispenser #(.kNumCoins(NC), .kNumItems(NI), .kTotalBits(TW), .kWaitTime(WT)) dut (
    .clk(clk), .reset(reset), .i_input_coin(i_input_coin), .i_output_item(i_output_item),
    .i_trigger_return(i_trigger_return), .coin_value(coin_value), .current_total(current_total),
    .wait_time(wait_time), .o_return_coin(o_return_coin), .o_busy(o_busy));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Index of the largest denomination that fits in the balance, or -1.
  function automatic int pick(input int unsigned tot);
    for (int i = NC - 1; i >= 0; i--)
      if (coin_value[i] <= tot) return i;
    return -1;
  endfunction

  function automatic int unsigned cval(input logic [NC-1:0] oh);
    int unsigned s = 0;
    for (int i = 0; i < NC; i++) if (oh[i]) s += coin_value[i];
    return s;
  endfunction

  function automatic bit gap_en();
`ifdef CHANGE_DISPENSE_GAP_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_busy = 0; m_phase = 0; m_wt = 0;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model at the
  // negedge, then step the model and the bench-side total register.
  task automatic cyc(input logic [NC-1:0] c, input logic [NI-1:0] it, input logic t);
    bit          act, disp, enter, nb, np;
    int          p;
    logic [NC-1:0] eret;
    int unsigned nw, ntot;
    i_input_coin = c; i_output_item = it; i_trigger_return = t;
    @(negedge clk);
    act  = (c != 0) || (it != 0);
    disp = !(gap_en() && m_phase);
    p    = pick(32'(current_total));
    eret = '0;
    if (m_busy && disp && p >= 0) eret[p] = 1'b1;
    chk("return_coin", 32'(o_return_coin), 32'(eret));
    chk("busy", 32'(o_busy), 32'(m_busy));
    chk("wait_time", wait_time, m_wt);
    enter = 0;
    if (!m_busy) begin
      enter = (current_total != 0) && (t || (m_wt == 1 && !act));
      nb = enter; np = 0;
    end else begin
      nb = !(act || (disp && p < 0));
      np = gap_en() ? !m_phase : 1'b0;
    end
    nw   = act ? WT : (enter ? 0 : (m_wt > 0 ? m_wt - 1 : 0));
    ntot = 32'(current_total) + cval(c) - cval(eret);
    @(posedge clk);
    #1;
    current_total = TW'(ntot);
    m_busy = nb; m_phase = np; m_wt = nw;
    i_input_coin = '0; i_output_item = '0; i_trigger_return = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, '0, 1'b0);
  endtask

  // Synchronous-looking reset pulse placed away from the edges.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic          trig;
    int unsigned   total;
    logic [NC-1:0] exp_ret;
    logic          exp_busy;
  } vec_t;

  vec_t vecs[$];

  initial begin
    reset = 1'b1;
    i_input_coin = '0; i_output_item = '0; i_trigger_return = 1'b0;
    coin_value = {32'd1000, 32'd500, 32'd100};
    current_total = '0;
    model_reset();
    #12 reset = 1'b0;
    @(posedge clk); #1;

    // Reset state
    chk("reset_wait", wait_time, 32'd0);
    chk("reset_ret", 32'(o_return_coin), 32'd0);
    chk("reset_busy", 32'(o_busy), 32'd0);

    // Greedy return of 1700 with the balance driven from the table
`ifdef CHANGE_DISPENSE_GAP_EN
    vecs = '{'{1'b1, 1700, 3'b000, 1'b0}, '{1'b0, 1700, 3'b100, 1'b1},
             '{1'b0,  700, 3'b000, 1'b1}, '{1'b0,  700, 3'b010, 1'b1},
             '{1'b0,  200, 3'b000, 1'b1}, '{1'b0,  200, 3'b001, 1'b1},
             '{1'b0,  100, 3'b000, 1'b1}, '{1'b0,  100, 3'b001, 1'b1},
             '{1'b0,    0, 3'b000, 1'b1}, '{1'b0,    0, 3'b000, 1'b1},
             '{1'b0,    0, 3'b000, 1'b0}};
`else
    vecs = '{'{1'b1, 1700, 3'b000, 1'b0}, '{1'b0, 1700, 3'b100, 1'b1},
             '{1'b0,  700, 3'b010, 1'b1}, '{1'b0,  200, 3'b001, 1'b1},
             '{1'b0,  100, 3'b001, 1'b1}, '{1'b0,    0, 3'b000, 1'b1},
             '{1'b0,    0, 3'b000, 1'b0}};
`endif
    foreach (vecs[k]) begin
      current_total = TW'(vecs[k].total);
      i_trigger_return = vecs[k].trig;
      @(negedge clk);
      chk($sformatf("tbl%0d_ret", k), 32'(o_return_coin), 32'(vecs[k].exp_ret));
      chk($sformatf("tbl%0d_busy", k), 32'(o_busy), 32'(vecs[k].exp_busy));
      chk($sformatf("tbl%0d_wait", k), wait_time, 32'd0);
      @(posedge clk); #1;
      i_trigger_return = 1'b0;
    end
    model_reset();
    current_total = '0;

    // Timer reload, countdown and timeout into a single 500 return
    cyc(3'b010, '0, 1'b0);
    chk("timer_reload", wait_time, 32'd10);
    idle(9);
    chk("timer_at_one", wait_time, 32'd1);
    idle(1);
    chk("timeout_busy", 32'(o_busy), 32'd1);
    chk("timeout_coin", 32'(o_return_coin), 32'b010);
    chk("timeout_wait", wait_time, 32'd0);
    idle(4);
    chk("timeout_done_busy", 32'(o_busy), 32'd0);
    chk("timeout_done_total", 32'(current_total), 32'd0);

    // Asynchronous reset with wait_time = 7
    cyc(3'b001, '0, 1'b0);
    idle(3);
    chk("pre_reset_wait", wait_time, 32'd7);
    do_reset();
    chk("async_reset_wait", wait_time, 32'd0);
    current_total = '0;

    // Reset in the middle of a return
    current_total = TW'(1700);
    cyc('0, '0, 1'b1);
    cyc('0, '0, 1'b0);
    do_reset();
    chk("midret_reset_busy", 32'(o_busy), 32'd0);
    chk("midret_reset_ret", 32'(o_return_coin), 32'd0);
    @(posedge clk); #1;

    // Residual below the smallest coin, then an empty balance
    current_total = TW'(50);
    cyc('0, '0, 1'b1);
    chk("residual_busy", 32'(o_busy), 32'd1);
    chk("residual_ret", 32'(o_return_coin), 32'd0);
    idle(1);
    chk("residual_exit", 32'(o_busy), 32'd0);
    chk("residual_kept", 32'(current_total), 32'd50);
    current_total = '0;
    cyc('0, '0, 1'b1);
    chk("empty_stays_idle", 32'(o_busy), 32'd0);

    // A coin inserted on the second dispense cycle aborts the return
    current_total = TW'(1700);
    cyc('0, '0, 1'b1);
    cyc('0, '0, 1'b0);
`ifdef CHANGE_DISPENSE_GAP_EN
    cyc('0, '0, 1'b0);
`endif
    cyc(3'b100, '0, 1'b0);
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_wait", wait_time, 32'd10);
    chk("abort_total", 32'(current_total), 32'd1200);

    // Activity in the timeout cycle wins
    idle(9);
    cyc(3'b001, '0, 1'b0);
    chk("act_vs_timeout_busy", 32'(o_busy), 32'd0);
    chk("act_vs_timeout_wait", wait_time, 32'd10);
    idle(30);
    chk("drain_total", 32'(current_total), 32'd0);

    // Randomized traffic with different denominations
    do_reset();
    coin_value = {32'd60, 32'd25, 32'd7};
    current_total = '0;
    @(posedge clk); #1;
    for (int n = 0; n < 3000; n++) begin
      logic [NC-1:0] c;
      logic [NI-1:0] it;
      logic t;
      c  = ($urandom_range(0, 9) == 0) ? NC'(1 << $urandom_range(0, NC - 1)) : '0;
      it = ($urandom_range(0, 19) == 0) ? NI'($urandom_range(1, 15)) : '0;
      t  = ($urandom_range(0, 14) == 0);
      cyc(c, it, t);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
